// File: rtl/fixed_special_ops_arbiter_pkg.sv
// Shared Q18.14 fixed-point constants and special-ops unit operation codes.
package fixed_special_ops_arbiter_pkg;

    localparam int FIXED_WIDTH = 32;
    localparam int FIXED_FRAC  = 14;

    localparam logic [31:0] FIXED_ZERO = 32'h0000_0000;
    localparam logic [31:0] FIXED_ONE  = 32'h0000_4000;

    localparam logic [3:0] OP_SQRT = 4'd0;
    localparam logic [3:0] OP_POW2 = 4'd1;
    localparam logic [3:0] OP_AVG  = 4'd4;
    localparam logic [3:0] OP_MAD  = 4'd8;

endpackage

// File: rtl/fixed_rr_arbiter.sv
// Round-robin grant: the first asserted request at or after ptr, wrapping modulo NREQ.
module fixed_rr_arbiter
    import fixed_special_ops_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index
);

    int   cand;
    logic found;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                index       = cand[IW-1:0];
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fixed_special_ops_arbiter.sv
// Shares one multi-cycle special-ops unit among NREQ requesters, with a watchdog
// that flushes the unit and answers on its behalf when it never completes.
module fixed_special_ops_arbiter
    import fixed_special_ops_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*32-1:0]        req_a,
    input  logic [NREQ*32-1:0]        req_b,
    input  logic [NREQ*4-1:0]         req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [31:0]               rsp_result,
    output logic                      rsp_overflow,
    output logic                      rsp_timeout,
    output logic                      alu_start,
    output logic [31:0]               alu_a,
    output logic [31:0]               alu_b,
    output logic [3:0]                alu_op,
    input  logic                      alu_done,
    input  logic [31:0]               alu_result,
    input  logic                      alu_overflow,
    output logic                      alu_reset
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   grant_index;
    logic [NREQ-1:0] grant;
    logic [CW-1:0]   wait_count;
    logic            transfer;

    fixed_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .index (grant_index)
    );

    // Ready is gated by reset too, so nothing can be accepted while reset is held.
    assign req_ready = (state == IDLE && !reset) ? grant : '0;
    assign transfer  = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            wait_count   <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= FIXED_ZERO;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
            alu_start    <= 1'b0;
            alu_reset    <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
        end else begin
            alu_start <= 1'b0;
            alu_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        alu_a     <= req_a[32*int'(grant_index) +: 32];
                        alu_b     <= req_b[32*int'(grant_index) +: 32];
                        alu_op    <= req_op[4*int'(grant_index) +: 4];
                        owner     <= grant_index;
                        alu_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_count <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A completion landing on the last allowed cycle still counts as success.
                    if (alu_done) begin
                        rsp_result   <= alu_result;
                        rsp_overflow <= alu_overflow;
                        rsp_timeout  <= 1'b0;
                        rsp_id       <= owner;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else if (wait_count == CW'(TIMEOUT - 1)) begin
                        rsp_result   <= FIXED_ZERO;
                        rsp_overflow <= 1'b1;
                        rsp_timeout  <= 1'b1;
                        rsp_id       <= owner;
                        rsp_valid    <= 1'b1;
                        alu_reset    <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
